// File: rtl/ddfs_pkg.sv
// Shared definitions for the DDFS phase path: default accumulator width and
// the FTW update-policy encodings used by phase_accum and ftw_shadow.
package ddfs_pkg;

  localparam int ACC_W_DEF     = 32;

  localparam int UPD_IMMEDIATE = 0;
  localparam int UPD_ON_WRAP   = 1;

endpackage : ddfs_pkg

// File: rtl/ftw_shadow.sv
// One-entry shadow register for the frequency tuning word: valid/ready intake,
// then transfer to the active word either immediately or at accumulator wrap.
module ftw_shadow
  import ddfs_pkg::*;
#(
  parameter int ACC_W    = ACC_W_DEF,
  parameter int UPD_MODE = UPD_IMMEDIATE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ACC_W-1:0] ftw_in,
  input  logic             ftw_valid,
  output logic             ftw_ready,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             wrap_gen,
  output logic [ACC_W-1:0] ftw_act
);

  localparam bit ON_WRAP = (UPD_MODE == UPD_ON_WRAP);

  logic             pend_full_q, pend_full_d;
  logic [ACC_W-1:0] pend_word_q, pend_word_d;
  logic [ACC_W-1:0] ftw_act_q,   ftw_act_d;
  logic             accept;
  logic             xfer;

  assign ftw_ready = ~pend_full_q;
  assign ftw_act   = ftw_act_q;
  assign accept    = ftw_valid & ~pend_full_q;

  // In on-wrap mode an idle or clearing cycle is also a safe moment to switch.
  assign xfer = ON_WRAP ? (pend_full_q & (wrap_gen | ~en | sync_clr))
                        : pend_full_q;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    pend_full_d = pend_full_q;
    pend_word_d = pend_word_q;
    ftw_act_d   = ftw_act_q;
    if (xfer) begin
      ftw_act_d   = pend_word_q;
      pend_full_d = 1'b0;
    end
    // accept and xfer are mutually exclusive: accept needs an empty slot.
    if (accept) begin
      pend_word_d = ftw_in;
      pend_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_full_q <= 1'b0;
      pend_word_q <= '0;
      ftw_act_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      pend_full_q <= pend_full_d;
      pend_word_q <= pend_word_d;
      ftw_act_q   <= ftw_act_d;
    end
  end

endmodule : ftw_shadow

// File: rtl/phase_accum.sv
// DDFS phase accumulator: acc advances by the active tuning word on each
// enabled edge; PA_out carries acc plus a phase offset, registered.
module phase_accum
  import ddfs_pkg::*;
#(
  parameter int ACC_W    = ACC_W_DEF,
  parameter int UPD_MODE = UPD_IMMEDIATE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync_clr,
  input  logic [ACC_W-1:0] ftw_in,
  input  logic             ftw_valid,
  output logic             ftw_ready,
  input  logic [ACC_W-1:0] pofs_in,
  input  logic             pofs_valid,
  output logic [ACC_W-1:0] PA_out,
  output logic             PA_valid,
  output logic             wrap
);

  logic [ACC_W-1:0] ftw_act;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic             wrap_gen;

  logic [ACC_W-1:0] acc_q,      acc_d;
  logic [ACC_W-1:0] pofs_act_q, pofs_act_d;
  logic [ACC_W-1:0] pa_out_q,   pa_out_d;
  logic             pa_valid_q, pa_valid_d;
  logic             wrap_q,     wrap_d;

  assign sum      = {1'b0, acc_q} + {1'b0, ftw_act};
  assign carry    = sum[ACC_W];
  assign wrap_gen = en & ~sync_clr & carry;

  ftw_shadow #(
    .ACC_W    (ACC_W),
    .UPD_MODE (UPD_MODE)
  ) u_ftw_shadow (
    .clk       (clk),
    .rst_n     (rst_n),
    .ftw_in    (ftw_in),
    .ftw_valid (ftw_valid),
    .ftw_ready (ftw_ready),
    .en        (en),
    .sync_clr  (sync_clr),
    .wrap_gen  (wrap_gen),
    .ftw_act   (ftw_act)
  );

  always_comb begin
    acc_d      = acc_q;
    pa_out_d   = pa_out_q;
    pa_valid_d = 1'b0;
    wrap_d     = 1'b0;
    pofs_act_d = pofs_valid ? pofs_in : pofs_act_q;
    // Clear wins over enable; the output then shows the bare offset.
    if (sync_clr) begin
      acc_d    = '0;
      pa_out_d = pofs_act_q;
    end else if (en) begin
      acc_d      = sum[ACC_W-1:0];
      pa_out_d   = sum[ACC_W-1:0] + pofs_act_q;
      pa_valid_d = 1'b1;
      wrap_d     = carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      pofs_act_q <= '0;
      pa_out_q   <= '0;
      pa_valid_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      pofs_act_q <= pofs_act_d;
      pa_out_q   <= pa_out_d;
      pa_valid_q <= pa_valid_d;
      wrap_q     <= wrap_d;
    end
  end

  assign PA_out   = pa_out_q;
  assign PA_valid = pa_valid_q;
  assign wrap     = wrap_q;

endmodule : phase_accum

// File: doc/phase_accum.md
PHASE_ACCUM -- requirements
Module: phase_accum

Interface
REQ-001 Parameter ACC_W, default 32: accumulator, tuning-word and phase-output width.
REQ-002 Parameter UPD_MODE, default 0: FTW update policy; 0 = immediate, 1 = on accumulator wrap.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1: single clock, rising-edge.
REQ-005 rst_n  in  1: asynchronous, active-low reset.
REQ-006 en  in  1: advance accumulator this cycle.
REQ-007 sync_clr  in  1: synchronous phase clear.
REQ-008 ftw_in  in  ACC_W: frequency tuning word.
REQ-009 ftw_valid  in  1: ftw_in offered.
REQ-010 ftw_ready  out  1: pending slot empty; accept when valid & ready.
REQ-011 pofs_in  in  ACC_W: phase offset.
REQ-012 pofs_valid  in  1: load pofs_in.
REQ-013 PA_out  out  ACC_W: phase word to the downstream phase-truncation stage.
REQ-014 PA_valid  out  1: PA_out updated this cycle.
REQ-015 wrap  out  1: accumulator overflowed, aligned with PA_out.

Function
REQ-016 The accumulator SHALL update on every en=1 edge: acc <= acc + ftw_act, modulo 2^ACC_W.
REQ-017 On the same edge, PA_out SHALL be (acc + ftw_act + pofs_act) mod 2^ACC_W; latency is 1 clock from en to PA_out.
REQ-018 On every edge, PA_valid SHALL be registered en; wrap SHALL be registered en & carry-out(acc + ftw_act).
REQ-019 With en=0, acc and PA_out SHALL hold, and PA_valid and wrap SHALL be 0.
REQ-020 FTW path is a one-entry shadow: accept when ftw_valid & ftw_ready; this sets pend_full and stores the word; ftw_ready = !pend_full.
REQ-021 With UPD_MODE=0, a pending word SHALL move to ftw_act on the edge after acceptance, and pend_full SHALL clear.
REQ-022 With UPD_MODE=1, a pending word SHALL move to ftw_act on the edge where wrap is generated, or on any edge with en=0 or sync_clr=1.
REQ-023 The accumulation on the transfer edge SHALL use the old ftw_act; the new word SHALL take effect from the next edge.
REQ-024 While pend_full=1, ftw_valid SHALL be ignored and ftw_in need not be held stable by the block; the source holds it per the handshake.
REQ-025 pofs_valid SHALL load pofs_act on the next edge; the loaded value SHALL first appear in PA_out on the following en edge.
REQ-026 sync_clr has priority over en: acc <= 0, PA_out <= pofs_act, PA_valid <= 0, wrap <= 0.
REQ-027 sync_clr SHALL NOT clear ftw_act or pofs_act.
REQ-028 ftw_in = 0 SHALL freeze the phase without error.
REQ-029 ftw_in = 2^(ACC_W-1) SHALL wrap every second enabled cycle.

Reset
REQ-030 On rst_n=0, the block SHALL immediately set acc, ftw_act, pofs_act, pending word, PA_out = 0; pend_full, PA_valid, wrap = 0; ftw_ready = 1.
REQ-031 Reset mid-operation SHALL discard any pending FTW; the first en edge after release SHALL give PA_out = ftw_act = 0.

Structure
REQ-032 Shared package ddfs_pkg SHALL hold ACC_W default and constants UPD_IMMEDIATE=0 and UPD_ON_WRAP=1.
REQ-033 The shadow register, handshake and transfer logic SHALL be sub-module ftw_shadow; accumulator and output registers stay in phase_accum.

Verification
REQ-034 Reset: assert rst_n=0 mid-run -> PA_out=0, PA_valid=0, wrap=0, ftw_ready=1 without waiting for clk.
REQ-035 UPD_MODE=0, ftw 0x4000_0000, en=1 -> PA_out 0x4000_0000, 0x8000_0000, 0xC000_0000, 0x0000_0000 with wrap=1 only on the fourth sample.
REQ-036 Backpressure: two back-to-back ftw_valid -> first accepted, ftw_ready=0 for one cycle, second accepted the cycle after.
REQ-037 UPD_MODE=1 with ftw 0x4000_0000 running; load 0x2000_0000 at acc=0x4000_0000 -> steps stay 0x4000_0000 through the wrap to 0, then 0x2000_0000.
REQ-038 Offset: ftw=0, pofs 0x8000_0000 -> PA_out 0x8000_0000 constant, and downstream octant bits [31:29] = 3'b100.
REQ-039 sync_clr at acc=0xC000_0000, pofs=0x1000_0000 -> PA_out=0x1000_0000 and PA_valid=0; the next en edge gives 0x1000_0000 + ftw_act.
